// File: rtl/cpu_int_pkg.sv
// Shared types and constants for the CPU interrupt path.
// Used by the upstream interrupt controller and its source synchronisers.
package cpu_int_pkg;

  localparam int VEC_W = 27;

  localparam logic [31:0] INSTR_NOOP = 32'h78000000;
  localparam logic [4:0]  OPC_JUMP   = 5'b10100;
  localparam logic [4:0]  OPC_RIN    = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    INJ,
    SVC
  } int_ctrl_state_t;

  function automatic logic [31:0] jump_instr(
    input logic [VEC_W-1:0] target
  );
    return {OPC_JUMP, target};
  endfunction

endpackage

// File: rtl/int_src_sync.sv
// Per-line synchroniser followed by a rising-edge detector.
// Emits a one-cycle pulse once the synchronised level goes high.
module int_src_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync[i] <= sync[i-1];
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/int_controller.sv
// Fixed-priority, non-nesting interrupt controller that raises INT,
// waits for ACK, injects a jump to the vector, then waits for eoi.
module int_controller
  import cpu_int_pkg::*;
#(
  parameter int               N_SRC       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [VEC_W-1:0] VEC_RESET   = 27'h6002000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             ACK,
  input  logic             eoi,
  output logic             INT,
  output logic [31:0]      INT_INSTR,
  output logic [3:0]       active_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  int_ctrl_state_t  state;
  logic [VEC_W-1:0] vec [N_SRC];
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic [3:0]       winner;
  logic [VEC_W-1:0] cur_vec;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:VEC_W];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    int_src_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .irq  (irq_src[g]),
      .rise (rise[g])
    );
  end

  assign eligible = pending & mask;

  always_comb begin
    winner  = '0;
    cur_vec = '0;
    clr     = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = 4'(i);
    for (int i = 0; i < N_SRC; i++) begin
      if (active_id == 4'(i)) cur_vec = vec[i];
      clr[i] = (state == REQ) && ACK && (active_id == 4'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      for (int i = 0; i < N_SRC; i++)
        vec[i] <= VEC_RESET;
    end else if (cfg_we) begin
      for (int i = 0; i < N_SRC; i++)
        if (cfg_addr == 5'(i)) vec[i] <= cfg_wdata[VEC_W-1:0];
      if (cfg_addr == 5'(N_SRC)) mask <= cfg_wdata[N_SRC-1:0];
    end
  end

  // New edges are ORed in after the clear, so a re-arm beats the ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      active_id <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (|eligible) begin
            active_id <= winner;
            state     <= REQ;
          end
        REQ: if (ACK) state <= INJ;
        INJ: state <= SVC;
        SVC: if (eoi) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign INT       = (state == REQ);
  assign busy      = (state != IDLE);
  assign INT_INSTR = (state == INJ) ? jump_instr(cur_vec) : INSTR_NOOP;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: handshake, priority, masking,
// re-arm during ACK, spurious strobes and asynchronous reset.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        ACK;
  logic        eoi;
  logic        INT;
  logic [31:0] INT_INSTR;
  logic [3:0]  active_id;
  logic        busy;
  logic [7:0]  pending;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOOP = 32'h78000000;

  int_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .ACK      (ACK),
    .eoi      (eoi),
    .INT      (INT),
    .INT_INSTR(INT_INSTR),
    .active_id(active_id),
    .busy     (busy),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_ack();
    ACK = 1'b1; tick(); ACK = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; ACK = 1'b0; eoi = 1'b0;
    tick(3);
    chk("rst_int", INT, 0);
    chk("rst_instr", INT_INSTR, NOOP);
    chk("rst_pend", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", active_id, 0);
    rst_n = 1'b1;
    tick();

    // basic handshake on source 3
    wr(5'd8, 32'h08);
    wr(5'd3, 32'h0000100);
    wr(5'd6, 32'h07FFFFFF);
    irq_src[3] = 1'b1;
    tick(2);
    chk("hs_pend_early", pending, 8'h00);
    tick();
    chk("hs_pend", pending, 8'h08);
    chk("hs_int_early", INT, 0);
    tick();
    chk("hs_int", INT, 1);
    chk("hs_id", active_id, 3);
    chk("hs_busy", busy, 1);
    tick(6);
    chk("hs_int_hold", INT, 1);
    pulse_ack();
    chk("hs_int_drop", INT, 0);
    chk("hs_jump", INT_INSTR, 32'hA0000100);
    chk("hs_pend_clr", pending, 8'h00);
    tick();
    chk("hs_noop", INT_INSTR, NOOP);
    tick(3);
    chk("hs_busy_svc", busy, 1);
    pulse_eoi();
    chk("hs_busy_idle", busy, 0);
    irq_src = '0;
    tick(4);

    // priority and no nesting
    wr(5'd8, 32'hFF);
    irq_src[5] = 1'b1; irq_src[2] = 1'b1;
    tick(3);
    chk("pr_pend", pending, 8'h24);
    tick();
    chk("pr_id2", active_id, 2);
    pulse_ack();
    tick();
    irq_src[0] = 1'b1;
    tick(4);
    chk("pr_pend_svc", pending, 8'h21);
    chk("pr_no_nest", INT, 0);
    pulse_eoi();
    chk("pr_idle_int", INT, 0);
    tick();
    chk("pr_int0", INT, 1);
    chk("pr_id0", active_id, 0);
    pulse_ack();
    tick();
    pulse_eoi();
    tick();
    chk("pr_int5", INT, 1);
    chk("pr_id5", active_id, 5);
    pulse_ack();
    tick();
    pulse_eoi();
    irq_src = '0;
    tick(4);

    // masking
    wr(5'd8, 32'h00);
    irq_src[1] = 1'b1;
    tick(3);
    chk("mk_pend", pending, 8'h02);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mk_int_low", INT, 0);
    end
    wr(5'd8, 32'h02);
    tick();
    chk("mk_int", INT, 1);
    chk("mk_id", active_id, 1);
    pulse_ack();
    tick();
    pulse_eoi();
    irq_src = '0;
    tick(4);

    // re-arm of source 4 on the ACK edge
    wr(5'd8, 32'hFF);
    irq_src[4] = 1'b1;
    tick(4);
    chk("ra_int", INT, 1);
    chk("ra_id", active_id, 4);
    irq_src[4] = 1'b0;
    tick(3);
    irq_src[4] = 1'b1;
    tick(2);
    pulse_ack();
    chk("ra_pend", pending, 8'h10);
    chk("ra_jump", INT_INSTR, 32'hA6002000);
    tick();
    pulse_eoi();
    tick();
    chk("ra_int2", INT, 1);
    chk("ra_id2", active_id, 4);
    pulse_ack();
    tick();
    pulse_eoi();
    irq_src = '0;
    tick(4);

    // spurious ACK / eoi, then reset in INJ
    pulse_ack();
    chk("sp_ack_busy", busy, 0);
    chk("sp_ack_int", INT, 0);
    irq_src[6] = 1'b1;
    tick(4);
    chk("sp_int", INT, 1);
    pulse_eoi();
    chk("sp_eoi_int", INT, 1);
    chk("sp_eoi_id", active_id, 6);
    pulse_ack();
    chk("sp_jump", INT_INSTR, 32'hA7FFFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_instr", INT_INSTR, NOOP);
    chk("ar_busy", busy, 0);
    chk("ar_pend", pending, 0);
    tick(2);
    rst_n = 1'b1;
    irq_src = '0;
    tick(2);
    chk("ar_int", INT, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
